// File: rtl/assoc_cache.sv
// assoc_cache: N-way set-associative write-back, write-allocate data cache.
//
// Sits between the CPU load/store unit and a block-wide main-memory port.
// Replacement is true LRU with a preference for invalid ways. Supports
// byte/half/word accesses and a flush that writes back every dirty line.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   cpu_valid_i ..     CPU request (held stable until cpu_ready_o)
//   cpu_ready_o        request completes this cycle (hit in COMPARE only)
//   cpu_rdata_o        zero-extended, right-aligned load data
//   flush_i            request write-back of all dirty lines
//   flush_done_o       one-cycle pulse at the end of the flush scan
//   mem_*              block-wide memory request/response handshake
module assoc_cache #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned WAYS        = 4,
    parameter int unsigned SETS        = 8,
    parameter int unsigned BLOCK_BYTES = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cpu_valid_i,
    input  logic                       cpu_wen_i,
    input  logic [1:0]                 cpu_size_i,
    input  logic [ADDR_W-1:0]          cpu_addr_i,
    input  logic [31:0]                cpu_wdata_i,
    output logic                       cpu_ready_o,
    output logic [31:0]                cpu_rdata_o,
    input  logic                       flush_i,
    output logic                       flush_done_o,
    output logic                       mem_valid_o,
    output logic                       mem_wen_o,
    output logic [ADDR_W-1:0]          mem_addr_o,
    output logic [BLOCK_BYTES*8-1:0]   mem_wdata_o,
    input  logic                       mem_ready_i,
    input  logic [BLOCK_BYTES*8-1:0]   mem_rdata_i
);

    localparam int unsigned OFF_W  = $clog2(BLOCK_BYTES);
    localparam int unsigned SET_W  = $clog2(SETS);
    localparam int unsigned WAY_W  = $clog2(WAYS);
    localparam int unsigned TAG_W  = ADDR_W - SET_W - OFF_W;
    localparam int unsigned LINE_W = BLOCK_BYTES * 8;
    localparam int unsigned IDX_W  = SET_W + WAY_W;

    typedef enum logic [2:0] {
        StCompare,
        StWriteBack,
        StAllocate,
        StFlushScan,
        StFlushWb
    } state_e;

    // Line storage (not reset)
    logic [LINE_W-1:0] data_q [SETS][WAYS];
    logic [TAG_W-1:0]  tag_q  [SETS][WAYS];

    // Line status and replacement state
    logic [SETS-1:0][WAYS-1:0] valid_q, valid_d;
    logic [SETS-1:0][WAYS-1:0] dirty_q, dirty_d;
    logic [WAY_W-1:0]          age_q [SETS][WAYS];
    logic [WAY_W-1:0]          age_d [SETS][WAYS];

    state_e            state_q, state_d;
    logic [WAY_W-1:0]  vic_way_q, vic_way_d;
    logic [SET_W-1:0]  vic_set_q, vic_set_d;
    logic [TAG_W-1:0]  miss_tag_q, miss_tag_d;
    logic [SET_W-1:0]  fl_set_q, fl_set_d;
    logic [WAY_W-1:0]  fl_way_q, fl_way_d;

    // Request decode
    logic [TAG_W-1:0]  req_tag;
    logic [SET_W-1:0]  req_set;
    logic [OFF_W-1:0]  req_off, off_a;
    logic [OFF_W+2:0]  sh;
    logic [31:0]       size_mask;

    assign req_tag = cpu_addr_i[ADDR_W-1 -: TAG_W];
    assign req_set = cpu_addr_i[OFF_W +: SET_W];
    assign req_off = cpu_addr_i[OFF_W-1:0];

    always_comb begin
        unique case (cpu_size_i)
            2'b00: begin
                off_a     = req_off;
                size_mask = 32'h0000_00ff;
            end
            2'b01: begin
                off_a     = {req_off[OFF_W-1:1], 1'b0};
                size_mask = 32'h0000_ffff;
            end
            default: begin
                off_a     = {req_off[OFF_W-1:2], 2'b00};
                size_mask = 32'hffff_ffff;
            end
        endcase
    end

    assign sh = {off_a, 3'b000};

    // Tag match and victim selection
    logic             hit_any;
    logic [WAY_W-1:0] hit_way;
    logic [WAY_W-1:0] victim_way;
    logic             inv_found;
    logic             cpu_hit;

    always_comb begin
        hit_any = 1'b0;
        hit_way = '0;
        for (int w = 0; w < int'(WAYS); w++) begin
            if (valid_q[req_set][w] && (tag_q[req_set][w] == req_tag)) begin
                hit_any = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    always_comb begin
        victim_way = '0;
        inv_found  = 1'b0;
        // Descending scan leaves the lowest-index invalid way selected
        for (int w = int'(WAYS) - 1; w >= 0; w--) begin
            if (!valid_q[req_set][w]) begin
                victim_way = WAY_W'(w);
                inv_found  = 1'b1;
            end
        end
        if (!inv_found) begin
            for (int w = 0; w < int'(WAYS); w++) begin
                if (age_q[req_set][w] == WAY_W'(WAYS - 1)) begin
                    victim_way = WAY_W'(w);
                end
            end
        end
    end

    assign cpu_hit = (state_q == StCompare) && cpu_valid_i && hit_any;

    // Hit-line datapath
    logic [LINE_W-1:0] rd_line, wr_shift, wr_mask, merged_line;
    logic [31:0]       load_word;

    assign rd_line     = data_q[req_set][hit_way];
    assign load_word   = 32'(rd_line >> sh) & size_mask;
    assign wr_shift    = LINE_W'(cpu_wdata_i) << sh;
    assign wr_mask     = LINE_W'(size_mask) << sh;
    assign merged_line = (rd_line & ~wr_mask) | (wr_shift & wr_mask);

    // Line selected for write-back (eviction victim or flush index)
    logic             in_flush;
    logic [SET_W-1:0] sel_set;
    logic [WAY_W-1:0] sel_way;
    logic             sel_vd;
    logic             fl_last;

    assign in_flush = (state_q == StFlushScan) || (state_q == StFlushWb);
    assign sel_set  = in_flush ? fl_set_q : vic_set_q;
    assign sel_way  = in_flush ? fl_way_q : vic_way_q;
    assign sel_vd   = valid_q[sel_set][sel_way] && dirty_q[sel_set][sel_way];
    assign fl_last  = ({fl_set_q, fl_way_q} == {IDX_W{1'b1}});

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StCompare;
            valid_q    <= '0;
            dirty_q    <= '0;
            vic_way_q  <= '0;
            vic_set_q  <= '0;
            miss_tag_q <= '0;
            fl_set_q   <= '0;
            fl_way_q   <= '0;
            for (int s = 0; s < int'(SETS); s++) begin
                for (int w = 0; w < int'(WAYS); w++) begin
                    age_q[s][w] <= WAY_W'(w);
                end
            end
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            dirty_q    <= dirty_d;
            vic_way_q  <= vic_way_d;
            vic_set_q  <= vic_set_d;
            miss_tag_q <= miss_tag_d;
            fl_set_q   <= fl_set_d;
            fl_way_q   <= fl_way_d;
            age_q      <= age_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        vic_way_d  = vic_way_q;
        vic_set_d  = vic_set_q;
        miss_tag_d = miss_tag_q;
        fl_set_d   = fl_set_q;
        fl_way_d   = fl_way_q;
        unique case (state_q)
            StCompare: begin
                if (cpu_valid_i) begin
                    if (!hit_any) begin
                        vic_way_d  = victim_way;
                        vic_set_d  = req_set;
                        miss_tag_d = req_tag;
                        if (valid_q[req_set][victim_way] && dirty_q[req_set][victim_way]) begin
                            state_d = StWriteBack;
                        end else begin
                            state_d = StAllocate;
                        end
                    end
                end else if (flush_i) begin
                    state_d  = StFlushScan;
                    fl_set_d = '0;
                    fl_way_d = '0;
                end
            end
            StWriteBack: begin
                if (mem_ready_i) state_d = StAllocate;
            end
            StAllocate: begin
                if (mem_ready_i) state_d = StCompare;
            end
            StFlushScan: begin
                if (sel_vd) begin
                    state_d = StFlushWb;
                end else if (fl_last) begin
                    state_d = StCompare;
                end else begin
                    {fl_set_d, fl_way_d} = {fl_set_q, fl_way_q} + IDX_W'(1);
                end
            end
            StFlushWb: begin
                if (mem_ready_i) begin
                    state_d = StFlushScan;
                    // The last line stays put; the scan then sees it clean and finishes
                    if (!fl_last) {fl_set_d, fl_way_d} = {fl_set_q, fl_way_q} + IDX_W'(1);
                end
            end
            default: state_d = StCompare;
        endcase
    end

    // Array update logic
    logic              data_we, tag_we;
    logic [SET_W-1:0]  wr_set;
    logic [WAY_W-1:0]  wr_way;
    logic [LINE_W-1:0] wr_line;

    always_comb begin
        valid_d = valid_q;
        dirty_d = dirty_q;
        age_d   = age_q;
        data_we = 1'b0;
        tag_we  = 1'b0;
        wr_set  = req_set;
        wr_way  = hit_way;
        wr_line = merged_line;

        if (cpu_hit) begin
            for (int w = 0; w < int'(WAYS); w++) begin
                if (WAY_W'(w) == hit_way) begin
                    age_d[req_set][w] = '0;
                end else if (age_q[req_set][w] < age_q[req_set][hit_way]) begin
                    age_d[req_set][w] = age_q[req_set][w] + WAY_W'(1);
                end
            end
            if (cpu_wen_i) begin
                data_we                  = 1'b1;
                dirty_d[req_set][hit_way] = 1'b1;
            end
        end

        if (((state_q == StWriteBack) || (state_q == StFlushWb)) && mem_ready_i) begin
            dirty_d[sel_set][sel_way] = 1'b0;
        end

        if ((state_q == StAllocate) && mem_ready_i) begin
            data_we                       = 1'b1;
            tag_we                        = 1'b1;
            wr_set                        = vic_set_q;
            wr_way                        = vic_way_q;
            wr_line                       = mem_rdata_i;
            valid_d[vic_set_q][vic_way_q] = 1'b1;
            dirty_d[vic_set_q][vic_way_q] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (data_we) data_q[wr_set][wr_way] <= wr_line;
        if (tag_we)  tag_q[wr_set][wr_way]  <= miss_tag_q;
    end

    // Output logic
    always_comb begin
        cpu_ready_o  = 1'b0;
        cpu_rdata_o  = '0;
        flush_done_o = 1'b0;
        mem_valid_o  = 1'b0;
        mem_wen_o    = 1'b0;
        mem_addr_o   = '0;
        mem_wdata_o  = '0;
        unique case (state_q)
            StCompare: begin
                if (cpu_hit) begin
                    cpu_ready_o = 1'b1;
                    if (!cpu_wen_i) cpu_rdata_o = load_word;
                end
            end
            StWriteBack, StFlushWb: begin
                mem_valid_o = 1'b1;
                mem_wen_o   = 1'b1;
                mem_addr_o  = {tag_q[sel_set][sel_way], sel_set, {OFF_W{1'b0}}};
                mem_wdata_o = data_q[sel_set][sel_way];
            end
            StAllocate: begin
                mem_valid_o = 1'b1;
                mem_addr_o  = {miss_tag_q, vic_set_q, {OFF_W{1'b0}}};
            end
            StFlushScan: begin
                flush_done_o = fl_last && !sel_vd;
            end
            default: ;
        endcase
    end

endmodule
